// File: rtl/stim_sequencer_if.sv
// stim_sequencer_if: handshake, drive and capture signals between a sweep controller and stim_sequencer.
// ones_cnt exists only when STIM_ONES_COUNT_EN is defined.
interface stim_sequencer_if #(parameter int WIDTH = 3);
  logic start;
  logic pause;
  logic gray;
  logic y_in;
  logic [WIDTH-1:0] x;
  logic busy;
  logic done;
  logic [2**WIDTH-1:0] tt;
`ifdef STIM_ONES_COUNT_EN
  logic [WIDTH:0] ones_cnt;
  modport master(output start, pause, gray, y_in, input x, busy, done, tt, ones_cnt);
  modport slave(input start, pause, gray, y_in, output x, busy, done, tt, ones_cnt);
`else
  modport master(output start, pause, gray, y_in, input x, busy, done, tt);
  modport slave(input start, pause, gray, y_in, output x, busy, done, tt);
`endif
endinterface

// File: rtl/stim_sequencer.sv
// stim_sequencer: clocked binary/Gray sweep of x with per-code hold and truth-table capture of y_in.
// Optional STIM_ONES_COUNT_EN adds ones_cnt, the number of 1 samples in the sweep.
module stim_sequencer #(
  parameter int WIDTH = 3,
  parameter int HOLD  = 20
) (
  input logic clk,
  input logic rst,
  stim_sequencer_if.slave s
);
  localparam int N  = 2**WIDTH;
  localparam int HW = $clog2(HOLD);
  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;
  state_t state, nxt;
  logic [WIDTH-1:0] idx;
  logic [HW-1:0] hold_cnt;
  logic gray_q;
  logic fire;
  logic term;
  function automatic logic [WIDTH-1:0] code(input logic [WIDTH-1:0] i, input logic g);
    return g ? i ^ (i >> 1) : i;
  endfunction
  assign fire = state == DRIVE && !s.pause && hold_cnt == HW'(HOLD - 1);
  assign term = idx == WIDTH'(N - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    s.busy = state == DRIVE;
    s.done = state == DONE;
    nxt = state == IDLE ? (s.start ? DRIVE : IDLE) :
          state == DRIVE ? (fire && term ? DONE : DRIVE) : IDLE;
  end
  // x is registered so source sees a clean, edge-aligned code for the whole hold window
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      idx <= '0;
      hold_cnt <= '0;
      gray_q <= 1'b0;
      s.x <= '0;
      s.tt <= '0;
`ifdef STIM_ONES_COUNT_EN
      s.ones_cnt <= '0;
`endif
    end else if (state == IDLE && s.start) begin
      idx <= '0;
      hold_cnt <= '0;
      gray_q <= s.gray;
      s.x <= '0;
      s.tt <= '0;
`ifdef STIM_ONES_COUNT_EN
      s.ones_cnt <= '0;
`endif
    end else if (fire) begin
      s.tt[code(idx, gray_q)] <= s.y_in;
`ifdef STIM_ONES_COUNT_EN
      s.ones_cnt <= s.ones_cnt + (WIDTH+1)'(s.y_in);
`endif
      if (term) s.x <= '0;
      else begin
        idx <= idx + 1'b1;
        hold_cnt <= '0;
        s.x <= code(idx + 1'b1, gray_q);
      end
    end else if (state == DRIVE && !s.pause) hold_cnt <= hold_cnt + 1'b1;
endmodule

// File: doc/stim_sequencer.md
Name:
stim_sequencer

Overview:
- Sequential stimulus-and-capture stage wrapped around the combinational `source` block.
- Drives the WIDTH-bit input x of `source` through every code in order, holding each code for HOLD clock cycles.
- Samples the 1-bit output y of `source` at the end of each hold window and assembles a 2^WIDTH-bit truth table.
- Replaces the hand-written delay sequence in the bench with a synthesizable, clocked sweep that has a start/done handshake.

Parameters:
- WIDTH, 3, bit width of x; the sweep covers 2^WIDTH codes.
- HOLD, 20, clock cycles each code is held; legal range is 2 or more.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  pulse that begins a sweep; accepted only in IDLE
- pause  input  1  while high, freezes the hold counter and the sweep position; x stays stable
- gray  input  1  sweep order select, latched when start is accepted: 0 = binary, 1 = Gray code
- y_in  input  1  output y of `source`
- x  output  WIDTH  code driven into `source`
- busy  output  1  high in the DRIVE state
- done  output  1  one-cycle pulse when a sweep completes
- tt  output  2^WIDTH  truth table; bit i holds y sampled while x == i

Behaviour:
- Reset (asynchronous, rst=1):
  - state = IDLE.
  - x, busy, done, tt, idx, hold_cnt and gray_q all go to 0.
- State IDLE:
  - x = 0, busy = 0.
  - tt keeps the result of the last sweep.
  - start=1 at a clock edge: go to DRIVE, idx=0, hold_cnt=0, gray_q=gray, tt cleared to 0.
- State DRIVE:
  - x = code(idx), where code = idx if gray_q=0, else idx ^ (idx>>1).
  - x is registered, so it changes only on clock edges.
  - busy = 1.
  - With pause=0, hold_cnt increments each cycle.
  - When hold_cnt == HOLD-1 and pause=0:
    - tt[code(idx)] <= y_in.
    - If idx == 2^WIDTH-1, go to DONE.
    - Otherwise idx increments and hold_cnt resets to 0.
  - With pause=1, nothing advances: no sample is taken, even at hold_cnt == HOLD-1.
  - start is ignored in DRIVE.
- State DONE (one cycle):
  - done = 1, busy = 0, x = 0.
  - Next state is IDLE unconditionally; start is ignored in this cycle.
- Latency:
  - x = first code and busy = 1 on the cycle after start is accepted.
  - An unpaused sweep lasts exactly 2^WIDTH × HOLD cycles in DRIVE, followed by 1 DONE cycle.
- Sampling:
  - y_in is sampled only in the last hold cycle of each code, giving `source` HOLD-1 cycles to settle.
- Widths:
  - idx is WIDTH+0 bits and wraps only through the terminal check.
  - hold_cnt is $clog2(HOLD) bits.
- Reset mid-sweep:
  - Immediate abort: all registers return to reset values and tt is cleared.
- Simultaneous start and pause:
  - In IDLE, start is accepted.
  - pause then applies from the first DRIVE cycle, so x holds the first code until pause falls.

Optional Feature:
- Macro: STIM_ONES_COUNT_EN.
- Defined:
  - Adds output ones_cnt [WIDTH:0] holding the number of samples where y_in = 1.
  - Cleared on reset and on start acceptance.
  - Increments in the same cycle a 1 is written into tt.
  - Valid when done = 1 and held until the next start.
- Undefined:
  - The port and its logic are absent.
  - All other behaviour is identical.

Test Plan:
- Binary sweep, WIDTH=3, HOLD=4, y_in = ^x, pulse start, gray=0 -> x steps 0,1,...,7, changing every 4 cycles; done pulses 33 cycles after start; tt = 8'b10010110; ones_cnt = 4 when enabled.
- Gray sweep, same setup with gray=1 -> x order 0,1,3,2,6,7,5,4; tt = 8'b10010110 (indexed by code, not step).
- y_in = x[2]&x[1], pause high for 6 cycles while x == 3 -> x holds at 3 for 10 cycles total; tt = 8'b11000000; done arrives 6 cycles later than an unpaused sweep.
- Start pulsed again while busy, and again during the DONE cycle -> both ignored; exactly one done pulse; the next start, given in IDLE, begins a new sweep and clears tt.
- Assert rst while x == 5 mid-sweep -> x, busy, done and tt read 0 immediately, without waiting for a clock edge; a following start sweeps from code 0.
- Constant y_in=1, WIDTH=3, HOLD=2 -> tt = 8'hFF after 17 cycles; ones_cnt = 8.
